// File: rtl/prbs_test_ctrl_if.sv
// Wrapper-side link of the PRBS run sequencer: reset, seed byte stream,
// repeat count out to the wrapper, detector flag back from it.
interface prbs_test_ctrl_if;
  logic       dut_rst;    // active-low reset to the wrapper
  logic [7:0] data_in;    // byte stream to the wrapper
  logic [1:0] n;          // repeat count to the wrapper
  logic       data_flag;  // detector flag from the wrapper

  // Sequencer side drives the wrapper controls and watches the flag.
  modport master (
    output dut_rst,
    output data_in,
    output n,
    input  data_flag
  );

  // Wrapper side.
  modport slave (
    input  dut_rst,
    input  data_in,
    input  n,
    output data_flag
  );
endinterface

// File: rtl/prbs_test_ctrl.sv
// Run-level sequencer for the PRBS-15 generator / byte-sequence-detector
// wrapper. Each run resets the wrapper, streams a 4-byte seed, then waits a
// bounded number of cycles for the detector flag. Runs and failed runs are
// counted over a campaign and a pass/fail verdict is pulsed to the host.
//
// Host handshake: i_start is a request sampled only while idle; o_busy is
// high from acceptance until the campaign ends or is aborted, and any start
// seen while busy is dropped. o_done pulses for one cycle with o_pass valid
// in that same cycle. i_abort wins over start and data_flag in every
// non-idle state. i_rst is the asynchronous active-low reset.
module prbs_test_ctrl #(
  parameter int TO_W       = 16,
  parameter int RUN_W      = 8,
  parameter int RST_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic [31:0]       i_pattern,
  input  logic [1:0]        i_rep_n,
  input  logic [RUN_W-1:0]  i_num_runs,
  input  logic [TO_W-1:0]   i_timeout_cycles,
  prbs_test_ctrl_if.master  wrp,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic [RUN_W-1:0]  o_run_cnt,
  output logic [RUN_W-1:0]  o_fail_cnt,
  output logic [2:0]        o_dbg_state
);

  localparam int RC_W = (RST_CYCLES < 2) ? 1 : $clog2(RST_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DUT_RST = 3'd1,
    S_LOAD    = 3'd2,
    S_WAIT    = 3'd3,
    S_REPORT  = 3'd4,
    S_FINISH  = 3'd5
  } state_t;

  state_t           r_state;
  logic [RC_W-1:0]  r_rst_cnt;
  logic [1:0]       r_load_cnt;
  logic [TO_W-1:0]  r_wait_cnt;
  logic             r_run_ok;

  // Campaign configuration captured at start.
  logic [31:0]      r_pattern;
  logic [TO_W-1:0]  r_timeout;
  logic [RUN_W-1:0] r_runs_tgt;

  logic             r_dut_rst;
  logic [7:0]       r_data_in;
  logic [1:0]       r_n;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [RUN_W-1:0] r_run_cnt;
  logic [RUN_W-1:0] r_fail_cnt;

  logic [7:0]       w_next_byte;
  logic [RUN_W-1:0] w_run_cnt_nxt;
  logic [RUN_W-1:0] w_runs_eff;

  // Byte that follows the one currently on data_in during LOAD.
  always_comb begin
    w_next_byte = r_pattern[7:0];
    case (r_load_cnt)
      2'd0:    w_next_byte = r_pattern[23:16];
      2'd1:    w_next_byte = r_pattern[15:8];
      default: w_next_byte = r_pattern[7:0];
    endcase
  end

  assign w_run_cnt_nxt = r_run_cnt + 1'b1;
  // A programmed run count of zero still runs once.
  assign w_runs_eff    = (i_num_runs == '0) ? RUN_W'(1) : i_num_runs;

  // Campaign sequencer: one run is DUT_RST -> LOAD -> WAIT -> REPORT.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= S_IDLE;
      r_rst_cnt  <= '0;
      r_load_cnt <= '0;
      r_wait_cnt <= '0;
      r_run_ok   <= 1'b0;
      r_pattern  <= '0;
      r_timeout  <= '0;
      r_runs_tgt <= '0;
      r_dut_rst  <= 1'b0;
      r_data_in  <= '0;
      r_n        <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_run_cnt  <= '0;
      r_fail_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state != S_IDLE && i_abort) begin
        // Counters and data_in keep their values; no done pulse.
        r_state   <= S_IDLE;
        r_dut_rst <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_dut_rst <= 1'b0;
            if (i_start) begin
              r_pattern  <= i_pattern;
              r_n        <= i_rep_n;
              r_runs_tgt <= w_runs_eff;
              r_timeout  <= i_timeout_cycles;
              r_run_cnt  <= '0;
              r_fail_cnt <= '0;
              r_pass     <= 1'b0;
              r_busy     <= 1'b1;
              r_data_in  <= '0;
              r_rst_cnt  <= '0;
              r_state    <= S_DUT_RST;
            end
          end
          S_DUT_RST: begin
            if (r_rst_cnt == RC_W'(RST_CYCLES - 1)) begin
              r_dut_rst  <= 1'b1;
              r_data_in  <= r_pattern[31:24];
              r_load_cnt <= '0;
              r_state    <= S_LOAD;
            end else begin
              r_rst_cnt <= r_rst_cnt + 1'b1;
            end
          end
          S_LOAD: begin
            if (r_load_cnt == 2'd3) begin
              r_wait_cnt <= '0;
              r_state    <= S_WAIT;
            end else begin
              r_data_in  <= w_next_byte;
              r_load_cnt <= r_load_cnt + 1'b1;
            end
          end
          S_WAIT: begin
            // Flag is checked first so a flag on the timeout cycle passes.
            if (wrp.data_flag) begin
              r_run_ok <= 1'b1;
              r_state  <= S_REPORT;
            end else if (r_wait_cnt == r_timeout) begin
              r_run_ok <= 1'b0;
              r_state  <= S_REPORT;
            end else begin
              r_wait_cnt <= r_wait_cnt + 1'b1;
            end
          end
          S_REPORT: begin
            r_run_cnt <= w_run_cnt_nxt;
            if (!r_run_ok && r_fail_cnt != '1) begin
              r_fail_cnt <= r_fail_cnt + 1'b1;
            end
            if (w_run_cnt_nxt == r_runs_tgt) begin
              r_state <= S_FINISH;
            end else begin
              r_dut_rst <= 1'b0;
              r_data_in <= '0;
              r_rst_cnt <= '0;
              r_state   <= S_DUT_RST;
            end
          end
          S_FINISH: begin
            r_done    <= 1'b1;
            r_pass    <= (r_fail_cnt == '0);
            r_busy    <= 1'b0;
            r_dut_rst <= 1'b0;
            r_state   <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign wrp.dut_rst = r_dut_rst;
  assign wrp.data_in = r_data_in;
  assign wrp.n       = r_n;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_pass      = r_pass;
  assign o_run_cnt   = r_run_cnt;
  assign o_fail_cnt  = r_fail_cnt;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_prbs_test_ctrl.sv
// Bench for prbs_test_ctrl. A campaign model expands the run list into the
// expected per-cycle trace of {busy, dut_rst, done, data_in} plus the flag
// stimulus, then the trace is replayed against the DUT.
module tb_prbs_test_ctrl;
  localparam int RST_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] pattern = '0;
  logic [1:0]  rep_n = '0;
  logic [7:0]  num_runs = '0;
  logic [15:0] timeout_cycles = '0;
  logic        busy, done, pass;
  logic [7:0]  run_cnt, fail_cnt;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_pass = 0;

  // Per-campaign scenario knobs.
  int m_dly[16];       // WAIT index at which flag pulses, -1 = never
  bit m_noise;         // pulse flag outside WAIT
  int m_abort_run;     // run in which abort is driven, -1 = none
  int m_abort_off;     // WAIT index of that abort
  int m_start_at;      // trace index at which a stray start is driven
  bit m_scramble;      // change config inputs mid-campaign

  prbs_test_ctrl_if wif ();

  prbs_test_ctrl #(.TO_W(16), .RUN_W(8), .RST_CYCLES(RST_CYCLES)) dut (
    .i_clk            (clk),
    .i_rst            (rst_n),
    .i_start          (start),
    .i_abort          (abort),
    .i_pattern        (pattern),
    .i_rep_n          (rep_n),
    .i_num_runs       (num_runs),
    .i_timeout_cycles (timeout_cycles),
    .wrp              (wif),
    .o_busy           (busy),
    .o_done           (done),
    .o_pass           (pass),
    .o_run_cnt        (run_cnt),
    .o_fail_cnt       (fail_cnt),
    .o_dbg_state      (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic clr_cfg();
    for (int i = 0; i < 16; i++) m_dly[i] = -1;
    m_noise     = 1'b0;
    m_abort_run = -1;
    m_abort_off = 0;
    m_start_at  = -1;
    m_scramble  = 1'b0;
  endtask

  task automatic run_campaign(input string tag, input logic [31:0] pat,
                              input logic [1:0] rep, input logic [7:0] runs,
                              input logic [15:0] to);
    logic [10:0] exp_q[$];
    bit          flag_q[$];
    int          rep_idx_q[$];
    bit          rep_ok_q[$];
    int          eff, abort_at, e, d, exp_runs, exp_fails;
    bit          ok, exp_pass;
    logic [7:0]  b3, bt;
    logic [10:0] got;

    eff      = (runs == 0) ? 1 : int'(runs);
    b3       = pat[7:0];
    abort_at = -1;
    for (int r = 0; r < eff; r++) begin
      d  = m_dly[r];
      ok = (d >= 0) && (d <= int'(to));
      e  = ok ? d : int'(to);
      for (int i = 0; i < RST_CYCLES; i++) begin
        exp_q.push_back({1'b1, 1'b0, 1'b0, 8'h00});
        flag_q.push_back(m_noise);
      end
      for (int i = 0; i < 4; i++) begin
        bt = pat[31 - 8*i -: 8];
        exp_q.push_back({1'b1, 1'b1, 1'b0, bt});
        flag_q.push_back(m_noise);
      end
      for (int w = 0; w <= e; w++) begin
        if (r == m_abort_run && w == m_abort_off) abort_at = exp_q.size();
        exp_q.push_back({1'b1, 1'b1, 1'b0, b3});
        flag_q.push_back(w == d);
      end
      rep_idx_q.push_back(exp_q.size());
      rep_ok_q.push_back(ok);
      exp_q.push_back({1'b1, 1'b1, 1'b0, b3});
      flag_q.push_back(m_noise);
    end
    if (abort_at >= 0) begin
      while (exp_q.size() > abort_at + 1) begin
        void'(exp_q.pop_back());
        void'(flag_q.pop_back());
      end
      bt = exp_q[abort_at][7:0];
      repeat (2) begin
        exp_q.push_back({1'b0, 1'b0, 1'b0, bt});
        flag_q.push_back(1'b0);
      end
    end else begin
      exp_q.push_back({1'b1, 1'b1, 1'b0, b3});
      flag_q.push_back(1'b0);
      exp_q.push_back({1'b0, 1'b0, 1'b1, b3});
      flag_q.push_back(1'b0);
      exp_q.push_back({1'b0, 1'b0, 1'b0, b3});
      flag_q.push_back(1'b0);
    end
    exp_runs  = 0;
    exp_fails = 0;
    foreach (rep_idx_q[i]) begin
      if (abort_at < 0 || rep_idx_q[i] < abort_at) begin
        exp_runs++;
        if (!rep_ok_q[i]) exp_fails++;
      end
    end
    exp_pass = (abort_at < 0) && (exp_fails == 0);

    // Driver
    pattern        = pat;
    rep_n          = rep;
    num_runs       = runs;
    timeout_cycles = to;
    start          = 1'b1;
    for (int k = 0; k < exp_q.size(); k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      abort = 1'b0;
      got = {busy, wif.dut_rst, done, wif.data_in};
      n_checks++;
      if (got !== exp_q[k]) begin
        $display("FAIL %s trace[%0d]: busy/dut_rst/done/data_in got %b/%b/%b/%h, expected %b/%b/%b/%h",
                 tag, k, got[10], got[9], got[8], got[7:0],
                 exp_q[k][10], exp_q[k][9], exp_q[k][8], exp_q[k][7:0]);
      end else n_pass++;
      if (k == 0) begin
        n_checks++;
        if (wif.n !== rep) $display("FAIL %s n: got %0d, expected %0d", tag, wif.n, rep);
        else n_pass++;
      end
      wif.data_flag = flag_q[k];
      abort = (k == abort_at);
      start = (k == m_start_at);
      if (m_scramble && k == 2) begin
        pattern        = $urandom;
        rep_n          = 2'($urandom_range(0, 3));
        num_runs       = 8'($urandom_range(0, 255));
        timeout_cycles = 16'($urandom_range(0, 65535));
      end
    end
    wif.data_flag = 1'b0;
    abort = 1'b0;
    start = 1'b0;

    // Scoreboard: end-of-campaign counters
    n_checks++;
    if (run_cnt !== 8'(exp_runs)) $display("FAIL %s run_cnt: got %0d, expected %0d", tag, run_cnt, exp_runs);
    else n_pass++;
    n_checks++;
    if (fail_cnt !== 8'(exp_fails)) $display("FAIL %s fail_cnt: got %0d, expected %0d", tag, fail_cnt, exp_fails);
    else n_pass++;
    n_checks++;
    if (pass !== exp_pass) $display("FAIL %s pass: got %b, expected %b", tag, pass, exp_pass);
    else n_pass++;
    n_checks++;
    if (wif.n !== rep) $display("FAIL %s n_hold: got %0d, expected %0d", tag, wif.n, rep);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, wif.dut_rst, done, pass} !== 4'b0000)
      $display("FAIL reset_ctrl: busy/dut_rst/done/pass got %b%b%b%b, expected 0000", busy, wif.dut_rst, done, pass);
    else n_pass++;
    n_checks++;
    if ({run_cnt, fail_cnt, wif.data_in, wif.n} !== 26'd0)
      $display("FAIL reset_data: run/fail/data_in/n got %0d/%0d/%h/%0d, expected 0/0/00/0", run_cnt, fail_cnt, wif.data_in, wif.n);
    else n_pass++;
  endtask

  task automatic test_single_pass();
    clr_cfg();
    m_dly[0] = 20;
    run_campaign("single_pass", 32'hCCDDEEFF, 2'd2, 8'd1, 16'd100);
  endtask

  task automatic test_timeout();
    clr_cfg();
    run_campaign("timeout", 32'h12345678, 2'd1, 8'd1, 16'd10);
  endtask

  task automatic test_multi_run();
    clr_cfg();
    m_dly[1] = 5;
    run_campaign("multi_run", 32'hA5C3_0F1E, 2'd3, 8'd3, 16'd15);
  endtask

  task automatic test_flag_on_timeout();
    clr_cfg();
    m_dly[0] = 7;
    m_noise  = 1'b1;
    run_campaign("flag_on_timeout", 32'h0102_0304, 2'd0, 8'd1, 16'd7);
  endtask

  task automatic test_zero_cfg();
    clr_cfg();
    m_dly[0] = 0;
    run_campaign("to0_flag", 32'hDEADBEEF, 2'd1, 8'd1, 16'd0);
    clr_cfg();
    run_campaign("runs0_to0", 32'hFEEDF00D, 2'd2, 8'd0, 16'd0);
  endtask

  task automatic test_abort();
    clr_cfg();
    m_dly[0]    = 2;
    m_abort_run = 1;
    m_abort_off = 5;
    run_campaign("abort", 32'h5566_7788, 2'd3, 8'd4, 16'd20);
    clr_cfg();
    m_dly[0]   = 4;
    m_dly[1]   = 6;
    m_start_at = 3;
    m_scramble = 1'b1;
    run_campaign("busy_start", 32'h99AA_BBCC, 2'd1, 8'd2, 16'd12);
  endtask

  task automatic test_random();
    for (int c = 0; c < 6; c++) begin
      clr_cfg();
      for (int r = 0; r < 16; r++) begin
        m_dly[r] = $urandom_range(0, 40);
        if (m_dly[r] > 32) m_dly[r] = -1;
      end
      m_noise    = 1'($urandom_range(0, 1));
      m_scramble = 1'b1;
      run_campaign($sformatf("random%0d", c), $urandom, 2'($urandom_range(0, 3)),
                   8'($urandom_range(0, 4)), 16'($urandom_range(0, 25)));
    end
  endtask

  task automatic test_async_reset();
    pattern        = 32'h8899AABB;
    rep_n          = 2'd3;
    num_runs       = 8'd5;
    timeout_cycles = 16'd0;
    start          = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Each failing run with timeout 0 spans 8 cycles; land inside run 3.
    repeat (20) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, wif.dut_rst, done, pass, run_cnt, fail_cnt, wif.data_in, wif.n} !== 30'd0)
      $display("FAIL async_reset: busy/dut_rst/done/pass/run/fail/data/n got %b/%b/%b/%b/%0d/%0d/%h/%0d, expected all 0",
               busy, wif.dut_rst, done, pass, run_cnt, fail_cnt, wif.data_in, wif.n);
    else n_pass++;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL async_reset_idle: busy got %b, expected 0", busy);
    else n_pass++;
  endtask

  initial begin
    wif.data_flag = 1'b0;
    clr_cfg();
    test_reset();
    test_single_pass();
    test_timeout();
    test_multi_run();
    test_flag_on_timeout();
    test_zero_cfg();
    test_abort();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
